// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters and owns the NZCV status register.
// Latency: accept -> rsp_valid in 2 cycles; one operation in flight, issue interval >= 3 cycles.
// Backpressure: rsp_ready low holds the response and blocks new accepts. ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_cmd,
    input  logic [3:0]       req1_cmd,
    input  logic [WIDTH-1:0] req0_val1,
    input  logic [WIDTH-1:0] req0_val2,
    input  logic [WIDTH-1:0] req1_val1,
    input  logic [WIDTH-1:0] req1_val2,
    input  logic             req0_s,
    input  logic             req1_s,
    output logic [WIDTH-1:0] alu_val1,
    output logic [WIDTH-1:0] alu_val2,
    output logic [3:0]       alu_cmd,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_nzcv,
    output logic [3:0]       status_nzcv,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             gnt;
    logic             op_s;
    logic             win;
    logic             accept;
    logic             is_arith;
    logic             is_logic;
    logic [WIDTH-1:0] res;
    logic [3:0]       nzcv_new;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic ptr;

    always_comb begin
        win = ptr;
        if (req_valid == 2'b01) begin
            win = 1'b0;
        end else if (req_valid == 2'b10) begin
            win = 1'b1;
        end
    end
`else
    // Requester 0 wins unless it is the only one idle
    assign win = (req_valid == 2'b10);
`endif

    assign accept    = rst_n && (state == IDLE) && (req_valid != 2'b00);
    assign req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;

    // Unknown commands return zero; only arithmetic commands own C and V
    always_comb begin
        is_arith = alu_cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
        is_logic = alu_cmd inside {4'b0001, 4'b1001, 4'b0110, 4'b0111, 4'b1000};
        res      = (is_arith || is_logic) ? alu_out : '0;
        nzcv_new = {res[WIDTH-1],
                    (res == '0),
                    is_arith ? alu_c : status_nzcv[1],
                    is_arith ? alu_v : status_nzcv[0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt          <= 1'b0;
            op_s         <= 1'b0;
            alu_val1     <= '0;
            alu_val2     <= '0;
            alu_cmd      <= 4'b0000;
            alu_carry_in <= 1'b0;
            rsp_valid    <= 2'b00;
            rsp_data     <= '0;
            rsp_nzcv     <= 4'b0000;
            status_nzcv  <= 4'b0000;
            busy         <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            ptr          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt      <= win;
                        alu_cmd  <= win ? req1_cmd  : req0_cmd;
                        alu_val1 <= win ? req1_val1 : req0_val1;
                        alu_val2 <= win ? req1_val2 : req0_val2;
                        op_s     <= win ? req1_s    : req0_s;
                        // Status only changes on EXEC edges, so C sampled here equals C at EXEC start
                        alu_carry_in <= status_nzcv[1];
                        busy     <= 1'b1;
                        state    <= EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        ptr      <= ~win;
`endif
                    end
                end
                EXEC: begin
                    rsp_data  <= res;
                    rsp_nzcv  <= nzcv_new;
                    if (op_s) begin
                        status_nzcv <= nzcv_new;
                    end
                    rsp_valid <= gnt ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, corner-case sequences, then random traffic against a transaction model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req0_cmd, req1_cmd;
    logic [31:0] req0_val1, req0_val2, req1_val1, req1_val2;
    logic        req0_s, req1_s;
    logic [31:0] alu_val1, alu_val2;
    logic [3:0]  alu_cmd;
    logic        alu_carry_in;
    logic [31:0] alu_out;
    logic        alu_c, alu_v;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_nzcv;
    logic [3:0]  status_nzcv;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .req0_val1(req0_val1), .req0_val2(req0_val2),
        .req1_val1(req1_val1), .req1_val2(req1_val2),
        .req0_s(req0_s), .req1_s(req1_s),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_nzcv(rsp_nzcv),
        .status_nzcv(status_nzcv), .busy(busy)
    );

    // External ALU: add/adc/sub/sbc, mov/mvn/and/orr/eor; junk flags on logical ops and junk data on unknown ops
    function automatic logic [33:0] alu_fn(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                           input logic cin);
        logic [32:0] sum;
        logic [31:0] r;
        logic        c, v;
        sum = 33'd0;
        r   = a ^ b ^ 32'hDEADBEEF;
        c   = a[0];
        v   = b[0];
        case (cmd)
            4'd2: sum = {1'b0, a} + {1'b0, b};
            4'd3: sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            4'd4: sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
            4'd5: sum = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
            4'd1: r = b;
            4'd9: r = ~b;
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            default: ;
        endcase
        if (cmd >= 4'd2 && cmd <= 4'd5) begin
            r = sum[31:0];
            c = sum[32];
            v = (cmd <= 4'd3) ? ((a[31] == b[31]) && (r[31] != a[31]))
                              : ((a[31] != b[31]) && (r[31] != a[31]));
        end
        return {c, v, r};
    endfunction

    always_comb {alu_c, alu_v, alu_out} = alu_fn(alu_cmd, alu_val1, alu_val2, alu_carry_in);

    // Expected {data, nzcv} for one operation given the status held before it
    function automatic logic [35:0] exp_fn(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] st);
        logic [33:0] raw;
        logic [31:0] d;
        logic        ar, lg;
        raw = alu_fn(cmd, a, b, st[1]);
        ar  = (cmd >= 4'd2) && (cmd <= 4'd5);
        lg  = cmd inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9};
        d   = (ar || lg) ? raw[31:0] : 32'd0;
        return {d, d[31], (d == 32'd0), ar ? raw[33] : st[1], ar ? raw[32] : st[0]};
    endfunction

    function automatic logic [1:0] oh(input int i);
        return (i != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic int mwin(input logic [1:0] v, input int p);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (v == 2'b11) return p;
`else
        if (v == 2'b11) return 0;
`endif
        return v[1] ? 1 : 0;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req_ready"}, req_ready, 0);
        chk({p, "_rsp_valid"}, rsp_valid, 0);
        chk({p, "_rsp_data"}, rsp_data, 0);
        chk({p, "_rsp_nzcv"}, rsp_nzcv, 0);
        chk({p, "_status"}, status_nzcv, 0);
        chk({p, "_alu_val1"}, alu_val1, 0);
        chk({p, "_alu_val2"}, alu_val2, 0);
        chk({p, "_alu_cmd"}, alu_cmd, 0);
        chk({p, "_alu_cin"}, alu_carry_in, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    task automatic set_req(input int r, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
        if (r == 0) begin
            req0_cmd = cmd; req0_val1 = a; req0_val2 = b; req0_s = s;
        end else begin
            req1_cmd = cmd; req1_val1 = a; req1_val2 = b; req1_s = s;
        end
    endtask

    // One operation on requester r; hold > 0 keeps the granted ready low for hold extra RESP cycles
    task automatic run_op(input int r, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold,
                          output logic [31:0] d, output logic [3:0] f, output logic cin);
        int n;
        int o;
        o = 1 - r;
        set_req(r, cmd, a, b, s);
        rsp_ready = (hold == 0) ? 2'b11 : oh(o);
        req_valid = oh(r);
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_ready", req_ready, oh(r));
        @(posedge clk); #1;
        req_valid = 2'b00;
        #1;
        cin = alu_carry_in;
        chk("exec_alu_cmd", alu_cmd, cmd);
        chk("exec_alu_val1", alu_val1, a);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_busy", busy, 1);
        @(posedge clk); #2;
        chk("resp_valid", rsp_valid, oh(r));
        d = rsp_data;
        f = rsp_nzcv;
        if (hold > 0) begin
            req_valid = oh(o);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #2;
                chk("bp_req_ready", req_ready, 0);
                chk("bp_rsp_valid", rsp_valid, oh(r));
                chk("bp_rsp_data", rsp_data, d);
            end
            req_valid = 2'b00;
            rsp_ready = oh(r);
        end
        @(posedge clk); #2;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] d;
        logic [3:0]  f;
        logic        cin;
        logic [3:0]  st;
    } vec_t;

    vec_t        tbl[12];
    logic [1:0]  pv;
    logic [3:0]  pcmd[2];
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic        ps[2];

    initial begin
        #600000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  f;
        logic        cin;
        int          exp_g[4];
        int          n;

        tbl[0]  = '{4'b0010, 32'd5,          32'd7,          1'b1, 32'd12,         4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0010, 32'hFFFFFFFF,   32'd1,          1'b1, 32'd0,          4'b0110, 1'b0, 4'b0110};
        tbl[2]  = '{4'b0011, 32'd0,          32'd0,          1'b1, 32'd1,          4'b0000, 1'b1, 4'b0000};
        tbl[3]  = '{4'b0010, 32'h80000000,   32'h80000000,   1'b1, 32'd0,          4'b0111, 1'b0, 4'b0111};
        tbl[4]  = '{4'b0110, 32'hF0,         32'h0F,         1'b1, 32'd0,          4'b0111, 1'b1, 4'b0111};
        tbl[5]  = '{4'b0100, 32'd3,          32'd5,          1'b0, 32'hFFFFFFFE,   4'b1000, 1'b1, 4'b0111};
        tbl[6]  = '{4'b1111, 32'd1,          32'd2,          1'b1, 32'd0,          4'b0111, 1'b1, 4'b0111};
        tbl[7]  = '{4'b1001, 32'd0,          32'd0,          1'b1, 32'hFFFFFFFF,   4'b1011, 1'b1, 4'b1011};
        tbl[8]  = '{4'b0101, 32'd10,         32'd3,          1'b1, 32'd7,          4'b0010, 1'b1, 4'b0010};
        tbl[9]  = '{4'b0111, 32'h80000000,   32'd1,          1'b0, 32'h80000001,   4'b1010, 1'b1, 4'b0010};
        tbl[10] = '{4'b0000, 32'd5,          32'd5,          1'b0, 32'd0,          4'b0110, 1'b1, 4'b0010};
        tbl[11] = '{4'b0001, 32'd9,          32'd0,          1'b1, 32'd0,          4'b0110, 1'b1, 4'b0110};

        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        set_req(0, 4'b0010, 32'd1, 32'd2, 1'b1);
        set_req(1, 4'b0010, 32'd3, 32'd4, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        chk("inrst_req_ready", req_ready, 0);
        chk("inrst_busy", busy, 0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        #1;
        chk_reset("rst");

        for (int i = 0; i < 12; i++) begin
            run_op(0, tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].s, 0, d, f, cin);
            chk($sformatf("vec%0d_data", i), d, tbl[i].d);
            chk($sformatf("vec%0d_nzcv", i), f, tbl[i].f);
            chk($sformatf("vec%0d_cin", i), cin, tbl[i].cin);
            chk($sformatf("vec%0d_status", i), status_nzcv, tbl[i].st);
        end

        run_op(0, 4'b0100, 32'd3, 32'd5, 1'b1, 5, d, f, cin);
        chk("bp_data", d, 32'hFFFFFFFE);
        chk("bp_nzcv", f, 4'b1000);
        chk("bp_status", status_nzcv, 4'b1000);

        set_req(0, 4'b0010, 32'd1, 32'd1, 1'b1);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("midrst_accept", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("midrst_exec_busy", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk_reset("midrst");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            chk("midrst_no_rsp", rsp_valid, 0);
            chk("midrst_idle", busy, 0);
        end

`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        set_req(0, 4'b0010, 32'd10, 32'd20, 1'b0);
        set_req(1, 4'b0010, 32'd100, 32'd200, 1'b0);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 10) begin
                @(posedge clk); #2;
                n++;
            end
            chk($sformatf("grant%0d", k), req_ready, oh(exp_g[k]));
            @(posedge clk); #2;
            @(posedge clk); #2;
            chk($sformatf("cont%0d_rsp_valid", k), rsp_valid, oh(exp_g[k]));
            chk($sformatf("cont%0d_rsp_data", k), rsp_data, (exp_g[k] != 0) ? 32'd300 : 32'd30);
            @(posedge clk); #2;
        end
        req_valid = 2'b00;

        // Random traffic against a transaction-level model
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pv = 2'b00;
        begin
            logic [3:0]  m_status;
            logic [31:0] m_d, m_a;
            logic [3:0]  m_f, m_cmd;
            logic        m_s, m_exec, m_resp;
            int          m_own, m_ptr, g;
            logic [35:0] e;
            logic [1:0]  exp_rdy;
            m_status = 4'b0000; m_exec = 1'b0; m_resp = 1'b0; m_ptr = 0; m_own = 0;
            m_d = 32'd0; m_f = 4'd0; m_s = 1'b0; m_cmd = 4'd0; m_a = 32'd0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!pv[i] && $urandom_range(0, 2) == 0) begin
                        pv[i]   = 1'b1;
                        pcmd[i] = 4'($urandom_range(0, 15));
                        pa[i]   = pick32();
                        pb[i]   = pick32();
                        ps[i]   = 1'($urandom_range(0, 1));
                    end
                end
                req_valid = pv;
                set_req(0, pcmd[0], pa[0], pb[0], ps[0]);
                set_req(1, pcmd[1], pa[1], pb[1], ps[1]);
                rsp_ready = 2'($urandom_range(0, 3));
                #1;
                g = mwin(pv, m_ptr);
                exp_rdy = (!m_exec && !m_resp && pv != 2'b00) ? oh(g) : 2'b00;
                chk("rnd_req_ready", req_ready, exp_rdy);
                chk("rnd_busy", busy, m_exec || m_resp);
                chk("rnd_status", status_nzcv, m_status);
                if (m_exec) begin
                    chk("rnd_alu_cmd", alu_cmd, m_cmd);
                    chk("rnd_alu_val1", alu_val1, m_a);
                    chk("rnd_alu_cin", alu_carry_in, m_status[1]);
                end
                chk("rnd_rsp_valid", rsp_valid, m_resp ? oh(m_own) : 2'b00);
                if (m_resp) begin
                    chk("rnd_rsp_data", rsp_data, m_d);
                    chk("rnd_rsp_nzcv", rsp_nzcv, m_f);
                end
                if (m_exec) begin
                    if (m_s) m_status = m_f;
                    m_exec = 1'b0;
                    m_resp = 1'b1;
                end else if (m_resp) begin
                    if (rsp_ready[m_own]) m_resp = 1'b0;
                end else if (pv != 2'b00) begin
                    e      = exp_fn(pcmd[g], pa[g], pb[g], m_status);
                    m_d    = e[35:4];
                    m_f    = e[3:0];
                    m_s    = ps[g];
                    m_cmd  = pcmd[g];
                    m_a    = pa[g];
                    m_own  = g;
                    m_exec = 1'b1;
                    m_ptr  = 1 - g;
                    pv[g]  = 1'b0;
                end
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single execute-stage ALU between two requesters, e.g. the main execute path and a compare/address-helper path. The block arbitrates, sequences each operation through a three-state FSM, and drives the ALU's operand, command and carry-in lines. It captures the result with derived NZCV flags, owns the architectural status register, and returns results over per-requester valid/ready handshakes.

## Interface
- `WIDTH`, 32, operand/result width; the ALU datapath is fixed at 32, so only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid` in 2: bit i means requester i presents an operation.
- `req_ready` out 2: bit i means requester i's operation is accepted this cycle.
- `req0_cmd`, `req1_cmd` in 4: ALU command per requester.
- `req0_val1`, `req0_val2`, `req1_val1`, `req1_val2` in 32: operands.
- `req0_s`, `req1_s` in 1: update the status register with this operation's flags.
- `alu_val1`, `alu_val2` out 32: operands to the ALU.
- `alu_cmd` out 4: command to the ALU.
- `alu_carry_in` out 1: carry input to the ALU.
- `alu_out` in 32: ALU result.
- `alu_c` in 1: ALU carry out.
- `alu_v` in 1: ALU overflow flag.
- `rsp_valid` out 2: bit i means the response for requester i is valid.
- `rsp_ready` in 2: requester i accepts its response.
- `rsp_data` out 32: result.
- `rsp_nzcv` out 4: flags of this operation.
- `status_nzcv` out 4: architectural status register, {N,Z,C,V}.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States are IDLE, EXEC and RESP. Reset enters IDLE.
- IDLE:
  - If any `req_valid` is set, pick a winner `g` and assert `req_ready[g]` for exactly that cycle (combinational, only in IDLE).
  - Latch `g`, cmd, val1, val2 and s. Go to EXEC.
  - The loser's `req_ready` stays 0; it keeps its request asserted.
- EXEC:
  - Drive `alu_*` from the latched operation.
  - Set `alu_carry_in` to `status_nzcv[1]`, the C flag as held at the start of EXEC.
  - Capture `rsp_data` from `alu_out`.
  - Derive flags:
    - N = `alu_out[31]`; Z = (`alu_out` == 0).
    - C = `alu_c` and V = `alu_v` for arithmetic commands 0010, 0011, 0100 and 0101.
    - For logical/move commands (0001, 1001, 0110, 0111, 1000), C and V keep their current `status_nzcv` values.
    - Any other cmd: result 0 with flags computed the same way, N=0, Z=1, C and V preserved.
  - If s=1, write the flags into `status_nzcv` on the same edge.
  - Go to RESP.
- In IDLE and RESP, the `alu_*` outputs hold the last latched operation; at reset they are 0.
- RESP:
  - `rsp_valid[g]`=1 until `rsp_ready[g]`=1. On that handshake edge return to IDLE.
  - `rsp_data` and `rsp_nzcv` stay stable while valid.
  - Ready on the non-granted bit is ignored.
- Arbitration (round-robin build):
  - A priority pointer `ptr` resets to 0.
  - When both requesters are valid, requester `ptr` wins.
  - After each acceptance, `ptr` is set to the loser's index, i.e. `~g`.
  - A single valid requester always wins.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_nzcv`=0, `status_nzcv`=0, `alu_*`=0, `busy`=0, `ptr`=0.
- Reset asserted in any state: the next edge forces IDLE, drops `rsp_valid`, clears the status register, and discards the in-flight operation.

## Timing
- Accept-to-`rsp_valid` latency is 2 cycles. The accept edge leaves IDLE; the EXEC edge captures the result.
- If `rsp_ready` is already high, the response handshake completes on the first RESP cycle.
- Minimum issue interval is 3 cycles per operation.
- The ALU is combinational. The path from the latched operands through the ALU to the result registers is one cycle.
- A flag-setting operation's status update is visible as `alu_carry_in` for the very next operation, because its EXEC comes at least 2 cycles later.
- `rsp_ready` held low keeps the block in RESP indefinitely; no new request is accepted meanwhile.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as described above.
- Macro undefined:
  - Fixed priority; requester 0 always wins when both are valid.
  - `ptr` is not implemented.
  - All other behaviour is identical.

## Test plan
- Single add:
  - Stimulus: req0 cmd=0010, val1=5, val2=7, s=1.
  - Response: `req_ready`=01 for the accept cycle; `rsp_valid`=01 two cycles later with `rsp_data`=12 and NZCV=0000; `status_nzcv`=0000.
- Carry chain:
  - Stimulus: req0 cmd=0010, 0xFFFFFFFF+1, s=1; then cmd=0011 (add with carry), 0+0.
  - Response: first result data=0 with NZCV=0110 (Z and C set); second op sees `alu_carry_in`=1 and returns data=1.
- Contention (round-robin build):
  - Stimulus: both requesters valid continuously for 4 operations, `rsp_ready` held high.
  - Response: grants in order 0,1,0,1; each response is routed to the correct `rsp_valid` bit.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles during RESP.
  - Response: `rsp_valid` and `rsp_data` stay stable; `req_ready` stays 0 throughout; the handshake completes on the cycle `rsp_ready` rises.
- Logical preserve:
  - Stimulus: set C=1 and V=1 via a signed add overflow; then cmd=0110 with 0xF0 & 0x0F, s=1.
  - Response: data=0 and `status_nzcv`=0111.
- Reset mid-op:
  - Stimulus: `rst_n`=0 for one cycle during EXEC.
  - Response: the next cycle is IDLE; all outputs are at their reset values; the response is never presented.
